// File: rtl/set_scan_if.sv
// Bundles the host handshake and the PE-facing coordinate/result signals of the
// set-coverage scan controller.
interface set_scan_if #(parameter int CNT_W = 7);
  logic             start_i;
  logic [1:0]       mode_i;
  logic [2:0]       covered_i;
  logic [7:0]       coord_o;
  logic             coord_vld_o;
  logic             busy_o;
  logic             valid_o;
  logic [CNT_W-1:0] candidate_o;

  modport slave  (input  start_i, mode_i, covered_i,
                  output coord_o, coord_vld_o, busy_o, valid_o, candidate_o);
  modport master (output start_i, mode_i, covered_i,
                  input  coord_o, coord_vld_o, busy_o, valid_o, candidate_o);
endinterface

// File: rtl/set_scan_ctrl.sv
// Walks the GRID x GRID lattice in x-major order, counts points whose PE cover
// vector satisfies the latched set mode, and reports the count with a valid pulse.
module set_scan_ctrl #(
  parameter int GRID  = 8,
  parameter int CNT_W = 7
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  set_scan_if.slave   bus
);
  localparam logic [3:0] LG = 4'(GRID);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_x, r_y;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_cnt, r_cand;
  logic             w_a, w_b, w_c, w_qual, w_last, w_accept;

  assign w_a      = bus.covered_i[2];
  assign w_b      = bus.covered_i[1];
  assign w_c      = bus.covered_i[0];
  assign w_last   = (r_x == LG) && (r_y == LG);
  assign w_accept = (r_state == S_IDLE) && bus.start_i;

  always_comb begin
    w_qual = 1'b0;
    case (r_mode)
      2'd0: w_qual = w_a;
      2'd1: w_qual = w_a & w_b;
      2'd2: w_qual = w_a ^ w_b;
      2'd3: w_qual = (w_a & w_b & ~w_c) | (w_a & ~w_b & w_c) | (~w_a & w_b & w_c);
      default: w_qual = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start_i) w_next = S_SCAN;
      S_SCAN: if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Coordinates freeze on the last point so coord_o holds it outside SCAN.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_x    <= 4'd1;
      r_y    <= 4'd1;
      r_mode <= 2'd0;
      r_cnt  <= '0;
      r_cand <= '0;
    end else if (w_accept) begin
      r_x    <= 4'd1;
      r_y    <= 4'd1;
      r_mode <= bus.mode_i;
      r_cnt  <= '0;
    end else if (r_state == S_SCAN) begin
      r_cnt <= r_cnt + CNT_W'(w_qual);
      if (w_last) begin
        r_cand <= r_cnt + CNT_W'(w_qual);
      end else if (r_x == LG) begin
        r_x <= 4'd1;
        r_y <= r_y + 4'd1;
      end else begin
        r_x <= r_x + 4'd1;
      end
    end
  end

  assign bus.coord_o     = {r_x, r_y};
  assign bus.coord_vld_o = (r_state == S_SCAN);
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.valid_o     = (r_state == S_DONE);
  assign bus.candidate_o = r_cand;
endmodule

// File: tb/tb_set_scan_ctrl.sv
// Directed bench for set_scan_ctrl: a cycle-indexed model predicts every output
// each cycle, and literal per-scan counts and latency pin the model itself.
module tb_set_scan_ctrl;
  localparam int G     = 8;
  localparam int CW    = 7;
  localparam int NPTS  = G * G;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pe_sel = 0;

  set_scan_if #(.CNT_W(CW)) bus ();

  set_scan_ctrl #(.GRID(G), .CNT_W(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // PE stand-ins: 0 constant 110, 1 circle A(4,4) r=2 with B/C off-grid r=0, 2 {x==y, x>4, 0}
  function automatic logic [2:0] pe_cov(input int sel, input int x, input int y);
    logic [2:0] v;
    v = 3'b000;
    case (sel)
      0: v = 3'b110;
      1: begin
        v[2] = ((x-4)*(x-4) + (y-4)*(y-4)) <= 4;
        v[1] = ((x-12)*(x-12) + (y-12)*(y-12)) <= 0;
        v[0] = ((x-14)*(x-14) + (y-1)*(y-1)) <= 0;
      end
      2: v = {x == y, x > 4, 1'b0};
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  function automatic bit qual(input int md, input logic [2:0] v);
    case (md)
      0: return v[2];
      1: return v[2] & v[1];
      2: return v[2] ^ v[1];
      default: return $countones(v) == 2;
    endcase
  endfunction

  function automatic int total(input int sel, input int md);
    int t = 0;
    for (int y = 1; y <= G; y++)
      for (int x = 1; x <= G; x++)
        t += int'(qual(md, pe_cov(sel, x, y)));
    return t;
  endfunction

  function automatic logic [7:0] pt(input int n);
    int p = n - 1;
    return {4'(p % G + 1), 4'(p / G + 1)};
  endfunction

  assign bus.covered_i = pe_cov(pe_sel, int'(bus.coord_o[7:4]), int'(bus.coord_o[3:0]));

  // Model: m_n = 0 idle, 1..NPTS scanning point m_n, NPTS+1 reporting.
  int         m_n     = 0;
  int         m_total = 0;
  int         m_cand  = 0;
  logic [7:0] m_coord = 8'h11;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n     <= 0;
      m_cand  <= 0;
      m_coord <= 8'h11;
    end else if (m_n == 0) begin
      if (bus.start_i) begin
        m_total <= total(pe_sel, int'(bus.mode_i));
        m_n     <= 1;
        m_coord <= pt(1);
      end
    end else if (m_n <= NPTS) begin
      m_n <= m_n + 1;
      if (m_n + 1 <= NPTS) m_coord <= pt(m_n + 1);
      else                 m_cand  <= m_total;
    end else begin
      m_n <= 0;
    end
  end

  int checks = 0, errors = 0;
  int lit_cand = 0, busy_len = 0;
  int to_req = 0, to_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (to_req != to_seen) begin
      errors += to_req - to_seen;
      to_seen = to_req;
      $display("FAIL timeout: no valid_o within bound at %0t", $time);
    end
    chk("busy",      int'(bus.busy_o),      int'(m_n != 0));
    chk("coord_vld", int'(bus.coord_vld_o), int'(m_n >= 1 && m_n <= NPTS));
    chk("valid",     int'(bus.valid_o),     int'(m_n == NPTS + 1));
    chk("candidate", int'(bus.candidate_o), m_cand);
    chk("coord",     int'(bus.coord_o),     int'(m_coord));
    if (bus.busy_o) busy_len++;
    else            busy_len = 0;
    if (bus.valid_o) begin
      chk("latency",   busy_len,              NPTS + 1);
      chk("lit_cand",  int'(bus.candidate_o), lit_cand);
      chk("model_lit", m_cand,                lit_cand);
    end
    if (!rst_n) begin
      chk("rst_busy",  int'(bus.busy_o),      0);
      chk("rst_valid", int'(bus.valid_o),     0);
      chk("rst_cand",  int'(bus.candidate_o), 0);
      chk("rst_coord", int'(bus.coord_o),     8'h11);
    end
  end

  // kind: 0 plain, 1 extra start pulses/mode toggles during scan and at valid, 2 reset at cycle 30
  task automatic run_scan(input int md, input int sel, input int lit, input int kind);
    int  n = 0;
    bit  done = 0;
    pe_sel   = sel;
    lit_cand = lit;
    bus.mode_i = 2'(md);
    @(posedge clk); #1 bus.start_i = 1'b1;
    @(posedge clk); #1 bus.start_i = 1'b0;
    bus.mode_i = 2'(md) ^ 2'b11;
    while (!done && n < 200) begin
      @(negedge clk); #1;
      n++;
      bus.start_i = 1'b0;
      if (bus.valid_o) begin
        done = 1;
        if (kind == 1) bus.start_i = 1'b1;
      end
      if (kind == 1 && (n == 10 || n == 40)) begin
        bus.start_i = 1'b1;
        bus.mode_i  = bus.mode_i + 2'd1;
      end
      if (kind == 2 && n == 30) rst_n = 1'b0;
      if (kind == 2 && n == 32) begin
        rst_n = 1'b1;
        done  = 1;
      end
    end
    if (kind == 1) begin
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    if (!done) to_req++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.mode_i  = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_scan(0, 0, 64, 0);
    run_scan(1, 0, 64, 0);
    run_scan(2, 0, 0,  0);
    run_scan(3, 0, 64, 0);
    run_scan(0, 1, 13, 0);
    run_scan(2, 2, 32, 0);
    run_scan(2, 2, 32, 1);
    run_scan(0, 0, 64, 2);
    run_scan(0, 1, 13, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/set_scan_ctrl.md
Name: set_scan_ctrl

Overview:
- Scan controller and accumulator for the set-coverage datapath.
- Walks every lattice point of the GRID x GRID field and drives each point to the PE.
- Consumes the PE's 3-bit covered vector {A,B,C} each cycle and counts the points that satisfy the selected set mode.
- Reports the count with a one-cycle valid pulse; sits directly around the PE, feeding coord_i and consuming covered_o.

Parameters:
- GRID, 8, points per axis; coordinates run 1..GRID; GRID <= 15.
- CNT_W, 7, width of candidate_o; must hold GRID*GRID (64 for the default).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  single-cycle request to begin a scan; sampled only in IDLE.
- mode_i  input  2  set mode; captured on the accepted start.
- covered_i  input  3  PE result for coord_o; [2]=A, [1]=B, [0]=C; combinational from coord_o, same cycle.
- coord_o  output  8  current point; [7:4]=x, [3:0]=y.
- coord_vld_o  output  1  high while coord_o holds a point being scanned.
- busy_o  output  1  high from accepted start until the cycle valid_o is asserted, inclusive.
- valid_o  output  1  one-cycle pulse; candidate_o is valid this cycle.
- candidate_o  output  CNT_W  count of qualifying points; held until the next accepted start.

Behaviour:
- Reset (async assert, synchronous release on the next clk_i edge):
  - state = IDLE.
  - coord_o = {4'd1, 4'd1}.
  - coord_vld_o = 0, busy_o = 0, valid_o = 0, candidate_o = 0.
  - Internal count = 0, latched mode = 0.
- FSM states IDLE, SCAN, DONE:
  - IDLE:
    - start_i = 1 -> capture mode_i, clear count, set x = 1, y = 1, go to SCAN.
    - busy_o rises in the next cycle.
  - SCAN:
    - coord_vld_o = 1, busy_o = 1.
    - Each cycle, evaluate covered_i against the latched mode; if the point qualifies, count += 1 at the edge.
    - Advance order: x increments first. When x = GRID, x wraps to 1 and y increments.
    - After the point (GRID, GRID) is evaluated, go to DONE.
    - Scan length is exactly GRID*GRID cycles.
  - DONE:
    - candidate_o = final count, valid_o = 1, busy_o = 1, coord_vld_o = 0.
    - Next state is IDLE.
- Qualification per latched mode, with A, B, C = covered_i[2], [1], [0]:
  - 0: A.
  - 1: A & B.
  - 2: A ^ B.
  - 3: exactly two of {A,B,C} set.
- Latency:
  - Accepted start at edge k -> first point presented in cycle k+1.
  - valid_o asserted in cycle k+1+GRID*GRID (cycle 65 after start for GRID = 8).
- Boundary conditions:
  - start_i while busy_o = 1: ignored; no restart, no mode change.
  - start_i in the same cycle valid_o is high: ignored, because the state is DONE. It is accepted only from IDLE.
  - mode_i changes during SCAN: no effect; the latched mode is used.
  - Count saturation is impossible for legal CNT_W; no wrap logic is required.
  - Reset mid-SCAN: immediate return to reset values; candidate_o is cleared and no valid_o pulse is produced.
  - coord_o outside SCAN holds its last value. It is don't-care for the PE because coord_vld_o = 0.

Test Plan:
- Reset, then start_i with mode 0 and covered_i stubbed constant 3'b110 -> 64 coordinates in x-major order from (1,1) to (8,8); valid_o in cycle 65 after start; candidate_o = 64.
- Same stub, modes 1, 2, 3 in sequence -> candidate_o = 64, 0, 64 respectively.
- Real PE model with circle A at (4,4), r = 2, B and C with r = 0 away from the grid, mode 0 -> candidate_o = 13.
- Bench model with covered_i = {x==y, x>4, 0}, mode 2 -> candidate_o = 32 (A^B: the 4 diagonal points with x<=4 plus the 28 off-diagonal points with x>4).
- start_i pulsed at cycles 10 and 40 of a scan, with mode_i toggled -> a single valid_o at the original cycle 65; result unchanged.
- rst_n_i low at scan cycle 30 for 2 cycles, then a new start -> outputs at reset values during reset; no stale valid_o; a clean 64-point scan follows with the correct count.
